cmt_stage: RTL and testbench
============================

Name: cmt_stage

Overview:
- Final pipeline stage of the dual-issue core; consumes the two commit slots registered by the MEM-to-commit pipeline register.
- Retires instructions in order: slot 0 is older, slot 1 is younger.
- Drives the two register-file write ports and owns the precise-exception state (EPC, Cause, Status.EXL, BadVAddr).
- Raises the pipeline-wide flush and the fetch redirect on an exception or ERET.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, fetch redirect target on any exception.
- RST_EXL, 1'b1, reset value of Status.EXL.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmt_in  in  CMT_REQUIRE[1:0]  commit slots; index 0 is older
- rf_we  out  2  register-file write enables, per slot
- rf_waddr  out  2x5  write addresses
- rf_wdata  out  2x32  write data
- flush_o  out  1  one-cycle pulse; clears every pipeline register upstream
- redirect_pc  out  32  fetch target, valid while flush_o=1
- epc_o  out  32  EPC register
- cause_exc_o  out  5  Cause.ExcCode
- cause_bd_o  out  1  Cause.BD
- status_exl_o  out  1  Status.EXL
- badvaddr_o  out  32  BadVAddr register
- instret_o  out  32  retired-instruction counter

Behaviour:
- CMT_REQUIRE fields: valid, pc[31:0], wreg_en, wreg_addr[4:0], wreg_data[31:0], exc_valid, exc_code[4:0], badvaddr[31:0], is_eret, in_delay_slot.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, flush_o=0, redirect_pc=0, epc_o=0, cause_exc_o=0, cause_bd_o=0, status_exl_o=RST_EXL, badvaddr_o=0, instret_o=0, FSM=RUN.
- Reset mid-flush returns the FSM to RUN. Any pending write or flush is dropped.
- FSM states:
  - RUN: evaluate slots every cycle.
  - FLUSH: exactly one cycle. cmt_in is ignored entirely (no writes, no exceptions, no count). Always returns to RUN.
- Slot evaluation in RUN (commit[i] = slot i retires):
  - trap0 = valid0 & (exc_valid0 | is_eret0).
  - trap1 = valid1 & (exc_valid1 | is_eret1).
  - trap0: slot 0 does not write; slot 1 is discarded.
  - trap1 without trap0: slot 0 commits normally; slot 1 does not write.
  - The first trapping slot is the "trap slot". The FSM goes to FLUSH next cycle; flush_o=1 during that cycle.
- Exception (trap slot has exc_valid=1):
  - cause_exc_o <= exc_code; redirect_pc <= EXC_VECTOR.
  - badvaddr_o <= badvaddr only for exc_code 4 (AdEL) or 5 (AdES).
  - If status_exl_o=0: epc_o <= in_delay_slot ? pc-4 : pc; cause_bd_o <= in_delay_slot.
  - If status_exl_o=1: EPC and BD are held.
  - status_exl_o <= 1.
- ERET (is_eret=1, exc_valid=0): redirect_pc <= epc_o; status_exl_o <= 0. No other CP0 change.
- exc_valid and is_eret both set: treated as an exception.
- Register writes:
  - Registered, latency 1: rf_* reflect cmt_in of the previous cycle.
  - rf_we[i] = commit[i] & wreg_en[i] & (wreg_addr[i]!=0).
  - If both slots write the same nonzero address, rf_we[0] is suppressed so the younger slot wins.
- Flush timing: flush_o and redirect_pc are registered and appear in the same cycle as the writes of the trap-cycle slot 0.
- instret_o: increments by the number of retiring slots (0, 1 or 2). A trapping slot does not count; ERET counts as retired. Wraps modulo 2^32.
- An invalid slot 0 with a valid slot 1 is legal; slot 1 is evaluated alone.

Decomposition:
- defines.svh / core package holds: CMT_REQUIRE struct, ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12), and the FSM enum {CMT_RUN, CMT_FLUSH}.
- One sub-module: cmt_cp0_regs. Holds EPC, Cause, Status.EXL and BadVAddr; takes a single trap-update strobe plus its fields.

Test Plan:
- Two valid slots with writes, r3=0x11 and r4=0x22 -> next cycle rf_we=2'b11, rf_wdata={0x22,0x11}, instret_o +2, flush_o=0.
- Both slots write r5 (0xA then 0xB) -> rf_we=2'b10, r5 receives 0xB. A write to r0 -> rf_we bit 0.
- Slot 0 AdEL, pc=0x8000_0100, badvaddr=0x1233, EXL=0 -> flush_o pulse, redirect_pc=0xBFC0_0380, epc_o=0x8000_0100, badvaddr_o=0x1233, slot 1 write dropped, instret_o unchanged.
- Slot 1 syscall in delay slot, pc=0x8000_0204 -> slot 0 write lands, epc_o=0x8000_0200, cause_bd_o=1, cause_exc_o=8. During the FLUSH cycle a valid cmt_in produces no writes.
- Exception while EXL=1 -> epc_o unchanged. Then ERET -> redirect_pc=epc_o, status_exl_o=0, instret_o +1.
- rst asserted during the FLUSH cycle -> next cycle all outputs at reset values, FSM=RUN, status_exl_o=1.

Source files
------------

// File: rtl/cmt_stage_pkg.sv
// Shared types for the commit stage: commit-slot record, CP0 ExcCodes, FSM states.
// Pure declarations; no latency or flow control of its own.
package cmt_stage_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic {
    CMT_RUN,
    CMT_FLUSH
  } cmt_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        wreg_en;
    logic [4:0]  wreg_addr;
    logic [31:0] wreg_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] badvaddr;
    logic        is_eret;
    logic        in_delay_slot;
  } cmt_require_t;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cmt_cp0_regs.sv
// Precise-exception CP0 state (EPC, Cause, Status.EXL, BadVAddr), updated by one trap strobe.
// Latency 1 from strobe to register; no backpressure, the strobe is always accepted.
module cmt_cp0_regs
  import cmt_stage_pkg::*;
#(
  parameter logic RST_EXL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_vld_i,
  input  logic        trap_is_exc_i,
  input  logic [4:0]  trap_exc_code_i,
  input  logic [31:0] trap_pc_i,
  input  logic        trap_bd_i,
  input  logic [31:0] trap_badvaddr_i,
  output logic [31:0] epc_o,
  output logic [4:0]  cause_exc_o,
  output logic        cause_bd_o,
  output logic        status_exl_o,
  output logic [31:0] badvaddr_o
);

  logic [31:0] epc_q, epc_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d;
  logic        exl_q, exl_d;
  logic [31:0] badv_q, badv_d;

  always_comb begin
    epc_d  = epc_q;
    exc_d  = exc_q;
    bd_d   = bd_q;
    exl_d  = exl_q;
    badv_d = badv_q;
    if (trap_vld_i) begin
      if (trap_is_exc_i) begin
        exc_d = trap_exc_code_i;
        if (is_addr_exc(trap_exc_code_i)) badv_d = trap_badvaddr_i;
        // A nested exception keeps the EPC/BD of the first one so the handler can return.
        if (!exl_q) begin
          epc_d = trap_bd_i ? trap_pc_i - 32'd4 : trap_pc_i;
          bd_d  = trap_bd_i;
        end
        exl_d = 1'b1;
      end else begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q  <= '0;
      exc_q  <= '0;
      bd_q   <= 1'b0;
      exl_q  <= RST_EXL;
      badv_q <= '0;
    end else begin
      epc_q  <= epc_d;
      exc_q  <= exc_d;
      bd_q   <= bd_d;
      exl_q  <= exl_d;
      badv_q <= badv_d;
    end
  end

  assign epc_o        = epc_q;
  assign cause_exc_o  = exc_q;
  assign cause_bd_o   = bd_q;
  assign status_exl_o = exl_q;
  assign badvaddr_o   = badv_q;

endmodule

// File: rtl/cmt_stage.sv
// In-order dual-slot retirement: register-file writes, trap handling, flush/redirect, instret.
// Latency 1 on all outputs; no backpressure, the cycle after a trap ignores cmt_in.
module cmt_stage
  import cmt_stage_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic        RST_EXL    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  cmt_require_t [1:0] cmt_in,
  output logic [1:0]         rf_we,
  output logic [1:0][4:0]    rf_waddr,
  output logic [1:0][31:0]   rf_wdata,
  output logic               flush_o,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        epc_o,
  output logic [4:0]         cause_exc_o,
  output logic               cause_bd_o,
  output logic               status_exl_o,
  output logic [31:0]        badvaddr_o,
  output logic [31:0]        instret_o
);

  cmt_state_e      state_q, state_d;
  logic [1:0]      trap;
  logic [1:0]      retire;
  logic            trap_vld;
  cmt_require_t    trap_slot;
  logic [1:0]      we_q, we_d;
  logic [1:0][4:0] waddr_q, waddr_d;
  logic [1:0][31:0] wdata_q, wdata_d;
  logic [31:0]     redirect_q, redirect_d;
  logic [31:0]     instret_q, instret_d;

  always_comb begin
    state_d    = state_q;
    trap       = '0;
    retire     = '0;
    trap_vld   = 1'b0;
    trap_slot  = cmt_in[0];
    we_d       = '0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    redirect_d = redirect_q;
    instret_d  = instret_q;
    if (state_q == CMT_RUN) begin
      for (int i = 0; i < 2; i++) begin
        trap[i]    = cmt_in[i].valid & (cmt_in[i].exc_valid | cmt_in[i].is_eret);
        waddr_d[i] = cmt_in[i].wreg_addr;
        wdata_d[i] = cmt_in[i].wreg_data;
      end
      // ERET traps but still retires; a faulting slot never retires.
      retire[0] = cmt_in[0].valid & ~cmt_in[0].exc_valid;
      retire[1] = cmt_in[1].valid & ~trap[0] & ~cmt_in[1].exc_valid;
      we_d[0] = cmt_in[0].valid & ~trap[0] & cmt_in[0].wreg_en
              & (cmt_in[0].wreg_addr != 5'd0);
      we_d[1] = cmt_in[1].valid & ~trap[0] & ~trap[1] & cmt_in[1].wreg_en
              & (cmt_in[1].wreg_addr != 5'd0);
      if ((we_d == 2'b11) && (cmt_in[0].wreg_addr == cmt_in[1].wreg_addr)) we_d[0] = 1'b0;
      instret_d = instret_q + {31'd0, retire[0]} + {31'd0, retire[1]};
      trap_vld  = |trap;
      trap_slot = trap[0] ? cmt_in[0] : cmt_in[1];
      if (trap_vld) begin
        state_d    = CMT_FLUSH;
        redirect_d = trap_slot.exc_valid ? EXC_VECTOR : epc_o;
      end
    end else begin
      state_d = CMT_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CMT_RUN;
      we_q       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      redirect_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      redirect_q <= redirect_d;
      instret_q  <= instret_d;
    end
  end

  cmt_cp0_regs #(
    .RST_EXL(RST_EXL)
  ) u_cp0 (
    .clk            (clk),
    .rst            (rst),
    .trap_vld_i     (trap_vld),
    .trap_is_exc_i  (trap_slot.exc_valid),
    .trap_exc_code_i(trap_slot.exc_code),
    .trap_pc_i      (trap_slot.pc),
    .trap_bd_i      (trap_slot.in_delay_slot),
    .trap_badvaddr_i(trap_slot.badvaddr),
    .epc_o          (epc_o),
    .cause_exc_o    (cause_exc_o),
    .cause_bd_o     (cause_bd_o),
    .status_exl_o   (status_exl_o),
    .badvaddr_o     (badvaddr_o)
  );

  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign flush_o     = (state_q == CMT_FLUSH);
  assign redirect_pc = redirect_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_cmt_stage.sv
// Directed and randomized bench for cmt_stage against a slot-level reference model.
module tb_cmt_stage;
  import cmt_stage_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic               clk = 1'b0;
  logic               rst;
  cmt_require_t [1:0] cmt_in;
  logic [1:0]         rf_we;
  logic [1:0][4:0]    rf_waddr;
  logic [1:0][31:0]   rf_wdata;
  logic               flush_o;
  logic [31:0]        redirect_pc, epc_o, badvaddr_o, instret_o;
  logic [4:0]         cause_exc_o;
  logic               cause_bd_o, status_exl_o;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_instret;

  // reference model state
  logic        m_flush, m_bd, m_exl;
  logic [1:0]  m_we;
  logic [4:0]  m_waddr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_redirect, m_epc, m_badv, m_instret;
  logic [4:0]  m_cause;

  cmt_stage dut (
    .clk(clk), .rst(rst), .cmt_in(cmt_in), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flush_o(flush_o), .redirect_pc(redirect_pc), .epc_o(epc_o),
    .cause_exc_o(cause_exc_o), .cause_bd_o(cause_bd_o), .status_exl_o(status_exl_o),
    .badvaddr_o(badvaddr_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  function automatic cmt_require_t mk(input logic v, input logic [31:0] pc, input logic wen,
                                      input logic [4:0] a, input logic [31:0] d,
                                      input logic exc, input logic [4:0] code,
                                      input logic [31:0] bv, input logic eret, input logic ds);
    cmt_require_t s;
    s.valid = v; s.pc = pc; s.wreg_en = wen; s.wreg_addr = a; s.wreg_data = d;
    s.exc_valid = exc; s.exc_code = code; s.badvaddr = bv; s.is_eret = eret; s.in_delay_slot = ds;
    return s;
  endfunction

  function automatic cmt_require_t wr(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    return mk(1'b1, pc, 1'b1, a, d, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endfunction

  function automatic cmt_require_t rnd_slot();
    logic [4:0] codes [7];
    cmt_require_t s;
    codes = '{EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV};
    s = '0;
    s.valid         = ($urandom_range(0, 9) < 8);
    s.pc            = $urandom & 32'hFFFF_FFFC;
    s.wreg_en       = ($urandom_range(0, 9) < 7);
    s.wreg_addr     = 5'($urandom_range(0, 7));
    s.wreg_data     = $urandom;
    s.exc_valid     = ($urandom_range(0, 9) == 0);
    s.exc_code      = codes[$urandom_range(0, 6)];
    s.badvaddr      = $urandom;
    s.is_eret       = ($urandom_range(0, 9) == 0);
    s.in_delay_slot = $urandom_range(0, 1) == 1;
    return s;
  endfunction

  task automatic cyc(input cmt_require_t s0, input cmt_require_t s1);
    cmt_in[0] = s0;
    cmt_in[1] = s1;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_flush = 0; m_we = 0; m_redirect = 0; m_epc = 0; m_badv = 0; m_instret = 0;
    m_cause = 0; m_bd = 0; m_exl = 1'b1;
    for (int i = 0; i < 2; i++) begin m_waddr[i] = 0; m_wdata[i] = 0; end
  endtask

  // Retirement rules: slots older than the first trap commit; an ERET trap slot counts.
  task automatic model_step(input cmt_require_t s0, input cmt_require_t s1);
    cmt_require_t s [2];
    int first;
    s[0] = s0; s[1] = s1;
    m_we = 2'b00;
    if (m_flush) begin
      m_flush = 0;
    end else begin
      first = -1;
      for (int i = 1; i >= 0; i--)
        if (s[i].valid && (s[i].exc_valid || s[i].is_eret)) first = i;
      for (int i = 0; i < 2; i++) begin
        if (s[i].valid && (first < 0 || i < first)) begin
          if (s[i].wreg_en && s[i].wreg_addr != 0) m_we[i] = 1'b1;
          m_waddr[i] = s[i].wreg_addr;
          m_wdata[i] = s[i].wreg_data;
        end
        if (s[i].valid && (first < 0 || i < first || (i == first && !s[i].exc_valid)))
          m_instret = m_instret + 1;
      end
      if (m_we == 2'b11 && m_waddr[0] == m_waddr[1]) m_we[0] = 1'b0;
      if (first >= 0) begin
        m_flush = 1;
        if (s[first].exc_valid) begin
          m_redirect = VEC;
          m_cause = s[first].exc_code;
          if (s[first].exc_code == 5'd4 || s[first].exc_code == 5'd5) m_badv = s[first].badvaddr;
          if (!m_exl) begin
            m_epc = s[first].in_delay_slot ? s[first].pc - 4 : s[first].pc;
            m_bd  = s[first].in_delay_slot;
          end
          m_exl = 1;
        end else begin
          m_redirect = m_epc;
          m_exl = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc('0, '0);
    cyc(wr(32'h100, 5'd3, 32'h5), wr(32'h104, 5'd4, 32'h6));
    total++; if ({rf_we, rf_waddr, rf_wdata} !== '0) $display("FAIL reset_rf got we=%b addr=%h data=%h exp 0", rf_we, rf_waddr, rf_wdata); else passed++;
    total++; if ({flush_o, redirect_pc, epc_o, cause_exc_o, cause_bd_o, badvaddr_o, instret_o} !== '0)
      $display("FAIL reset_regs got flush=%b rpc=%h epc=%h exc=%0d bd=%b badv=%h ir=%0d exp all 0", flush_o, redirect_pc, epc_o, cause_exc_o, cause_bd_o, badvaddr_o, instret_o); else passed++;
    total++; if (status_exl_o !== 1'b1) $display("FAIL reset_exl got %b exp 1", status_exl_o); else passed++;
    rst = 1'b0;
    exp_instret = 0;
  endtask

  task automatic test_dual_write();
    cyc(wr(32'h8000_0000, 5'd3, 32'h11), wr(32'h8000_0004, 5'd4, 32'h22));
    exp_instret += 2;
    total++; if (rf_we !== 2'b11) $display("FAIL dual_we got %b exp 11", rf_we); else passed++;
    total++; if (rf_wdata !== {32'h22, 32'h11} || rf_waddr !== {5'd4, 5'd3})
      $display("FAIL dual_data got %h/%h exp 00000022_00000011/04_03", rf_wdata, rf_waddr); else passed++;
    total++; if (instret_o !== exp_instret || flush_o !== 1'b0)
      $display("FAIL dual_instret got ir=%0d fl=%b exp ir=%0d fl=0", instret_o, flush_o, exp_instret); else passed++;
  endtask

  task automatic test_same_addr();
    cyc(wr(32'h8000_0008, 5'd5, 32'hA), wr(32'h8000_000C, 5'd5, 32'hB));
    exp_instret += 2;
    total++; if (rf_we !== 2'b10 || rf_waddr[1] !== 5'd5 || rf_wdata[1] !== 32'hB)
      $display("FAIL same_addr got we=%b a1=%0d d1=%h exp we=10 a1=5 d1=b", rf_we, rf_waddr[1], rf_wdata[1]); else passed++;
    cyc(wr(32'h8000_0010, 5'd0, 32'h77), '0);
    exp_instret += 1;
    total++; if (rf_we !== 2'b00 || instret_o !== exp_instret)
      $display("FAIL r0_write got we=%b ir=%0d exp we=00 ir=%0d", rf_we, instret_o, exp_instret); else passed++;
  endtask

  task automatic test_eret(input logic [31:0] exp_rpc);
    cyc(mk(1'b1, 32'h8000_0300, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0),
        wr(32'h8000_0304, 5'd9, 32'h99));
    exp_instret += 1;
    total++; if (flush_o !== 1'b1 || redirect_pc !== exp_rpc || status_exl_o !== 1'b0)
      $display("FAIL eret got fl=%b rpc=%h exl=%b exp fl=1 rpc=%h exl=0", flush_o, redirect_pc, status_exl_o, exp_rpc); else passed++;
    total++; if (instret_o !== exp_instret || rf_we !== 2'b00)
      $display("FAIL eret_retire got ir=%0d we=%b exp ir=%0d we=00", instret_o, rf_we, exp_instret); else passed++;
    cyc('0, '0);
  endtask

  task automatic test_adel();
    cyc(mk(1'b1, 32'h8000_0100, 1'b1, 5'd6, 32'h66, 1'b1, EXC_ADEL, 32'h1233, 1'b0, 1'b0),
        wr(32'h8000_0104, 5'd7, 32'h77));
    total++; if (flush_o !== 1'b1 || redirect_pc !== VEC)
      $display("FAIL adel_flush got fl=%b rpc=%h exp fl=1 rpc=%h", flush_o, redirect_pc, VEC); else passed++;
    total++; if (epc_o !== 32'h8000_0100 || badvaddr_o !== 32'h1233 || cause_exc_o !== 5'd4 || cause_bd_o !== 1'b0)
      $display("FAIL adel_cp0 got epc=%h badv=%h exc=%0d bd=%b exp 80000100 1233 4 0", epc_o, badvaddr_o, cause_exc_o, cause_bd_o); else passed++;
    total++; if (rf_we !== 2'b00 || instret_o !== exp_instret || status_exl_o !== 1'b1)
      $display("FAIL adel_drop got we=%b ir=%0d exl=%b exp 00 %0d 1", rf_we, instret_o, status_exl_o, exp_instret); else passed++;
    cyc('0, '0);
    total++; if (flush_o !== 1'b0) $display("FAIL flush_pulse got %b exp 0", flush_o); else passed++;
  endtask

  task automatic test_syscall_bd();
    cyc(wr(32'h8000_0200, 5'd8, 32'h88),
        mk(1'b1, 32'h8000_0204, 1'b1, 5'd9, 32'h99, 1'b1, EXC_SYS, 32'hDEAD, 1'b0, 1'b1));
    exp_instret += 1;
    total++; if (rf_we !== 2'b01 || rf_waddr[0] !== 5'd8 || rf_wdata[0] !== 32'h88)
      $display("FAIL sys_write got we=%b a0=%0d d0=%h exp 01 8 88", rf_we, rf_waddr[0], rf_wdata[0]); else passed++;
    total++; if (epc_o !== 32'h8000_0200 || cause_bd_o !== 1'b1 || cause_exc_o !== 5'd8 || badvaddr_o !== 32'h1233)
      $display("FAIL sys_cp0 got epc=%h bd=%b exc=%0d badv=%h exp 80000200 1 8 1233", epc_o, cause_bd_o, cause_exc_o, badvaddr_o); else passed++;
    total++; if (flush_o !== 1'b1 || instret_o !== exp_instret)
      $display("FAIL sys_flush got fl=%b ir=%0d exp 1 %0d", flush_o, instret_o, exp_instret); else passed++;
    cyc(wr(32'h8000_0208, 5'd10, 32'hAA), wr(32'h8000_020C, 5'd11, 32'hBB));
    total++; if (rf_we !== 2'b00 || flush_o !== 1'b0 || instret_o !== exp_instret)
      $display("FAIL flush_ignore got we=%b fl=%b ir=%0d exp 00 0 %0d", rf_we, flush_o, instret_o, exp_instret); else passed++;
  endtask

  task automatic test_exl_nested();
    cyc(mk(1'b1, 32'h8000_0400, 1'b0, 5'd0, 32'd0, 1'b1, EXC_OV, 32'd0, 1'b1, 1'b0), '0);
    total++; if (epc_o !== 32'h8000_0200 || cause_bd_o !== 1'b1 || cause_exc_o !== 5'd12 || redirect_pc !== VEC)
      $display("FAIL nested got epc=%h bd=%b exc=%0d rpc=%h exp 80000200 1 12 %h", epc_o, cause_bd_o, cause_exc_o, redirect_pc, VEC); else passed++;
    total++; if (instret_o !== exp_instret) $display("FAIL nested_ir got %0d exp %0d", instret_o, exp_instret); else passed++;
    cyc('0, '0);
    test_eret(32'h8000_0200);
  endtask

  task automatic test_reset_mid_flush();
    cyc(mk(1'b1, 32'h8000_0500, 1'b0, 5'd0, 32'd0, 1'b1, EXC_RI, 32'd0, 1'b0, 1'b0), '0);
    total++; if (flush_o !== 1'b1) $display("FAIL pre_rst_flush got %b exp 1", flush_o); else passed++;
    rst = 1'b1;
    cyc(wr(32'h8000_0504, 5'd12, 32'hC), '0);
    total++; if ({rf_we, flush_o, redirect_pc, epc_o, cause_exc_o, cause_bd_o, badvaddr_o, instret_o} !== '0 || status_exl_o !== 1'b1)
      $display("FAIL rst_flush got we=%b fl=%b rpc=%h epc=%h exc=%0d ir=%0d exl=%b exp zeros exl=1", rf_we, flush_o, redirect_pc, epc_o, cause_exc_o, instret_o, status_exl_o); else passed++;
    rst = 1'b0;
    cyc(wr(32'h8000_0600, 5'd1, 32'h1), wr(32'h8000_0604, 5'd2, 32'h2));
    total++; if (rf_we !== 2'b11 || flush_o !== 1'b0 || instret_o !== 32'd2)
      $display("FAIL post_rst_run got we=%b fl=%b ir=%0d exp 11 0 2", rf_we, flush_o, instret_o); else passed++;
  endtask

  task automatic test_random();
    cmt_require_t s0, s1;
    rst = 1'b1;
    cyc('0, '0);
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      s0 = rnd_slot();
      s1 = rnd_slot();
      model_step(s0, s1);
      cyc(s0, s1);
      total++; if (rf_we !== m_we || flush_o !== m_flush)
        $display("FAIL rnd_we[%0d] got we=%b fl=%b exp we=%b fl=%b", n, rf_we, flush_o, m_we, m_flush); else passed++;
      for (int i = 0; i < 2; i++) if (m_we[i]) begin
        total++; if (rf_waddr[i] !== m_waddr[i] || rf_wdata[i] !== m_wdata[i])
          $display("FAIL rnd_wdat[%0d].%0d got %0d/%h exp %0d/%h", n, i, rf_waddr[i], rf_wdata[i], m_waddr[i], m_wdata[i]); else passed++;
      end
      if (m_flush) begin
        total++; if (redirect_pc !== m_redirect)
          $display("FAIL rnd_rpc[%0d] got %h exp %h", n, redirect_pc, m_redirect); else passed++;
      end
      total++; if (epc_o !== m_epc || cause_exc_o !== m_cause || cause_bd_o !== m_bd || status_exl_o !== m_exl || badvaddr_o !== m_badv)
        $display("FAIL rnd_cp0[%0d] got %h %0d %b %b %h exp %h %0d %b %b %h", n, epc_o, cause_exc_o, cause_bd_o, status_exl_o, badvaddr_o, m_epc, m_cause, m_bd, m_exl, m_badv); else passed++;
      total++; if (instret_o !== m_instret)
        $display("FAIL rnd_instret[%0d] got %0d exp %0d", n, instret_o, m_instret); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    cmt_in = '0;
    exp_instret = 0;
    test_reset();
    test_dual_write();
    test_same_addr();
    test_eret(32'h0);
    test_adel();
    test_eret(32'h8000_0100);
    test_syscall_bd();
    test_exl_nested();
    test_reset_mid_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
